// File: rtl/clk_time_counter.sv
// ============================================================================
// Module   : clk_time_counter
// Brief    : Synchronises the divided seconds clock, detects its rising edge
//            and advances a BCD HH:MM:SS counter with load/pause control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_time_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_in,
    input  logic       i_pause,
    input  logic       i_set_valid,
    output logic       o_set_ready,
    input  logic [7:0] i_set_hh,
    input  logic [7:0] i_set_mm,
    input  logic [7:0] i_set_ss,
    output logic       o_set_err,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_sec_pulse,
    output logic       o_min_pulse,
    output logic       o_hour_pulse,
    output logic       o_day_pulse
);

    localparam logic [7:0] c_HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] c_MS_MAX_BCD   = 8'h59;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_edge;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_advance;
    logic                   w_ss_wrap;
    logic                   w_mm_wrap;
    logic                   w_hh_wrap;
    logic [7:0]             r_hh;
    logic [7:0]             r_mm;
    logic [7:0]             r_ss;
    logic                   r_set_err;
    logic                   r_sec_pulse;
    logic                   r_min_pulse;
    logic                   r_hour_pulse;
    logic                   r_day_pulse;

    // With both digits <= 9, BCD ordering equals numeric ordering.
    function automatic logic f_bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign o_set_ready = ~rst;
    assign w_accept    = i_set_valid & o_set_ready;
    assign w_legal     = f_bcd_ok(i_set_hh, c_HOUR_MAX_BCD) &&
                         f_bcd_ok(i_set_mm, c_MS_MAX_BCD)   &&
                         f_bcd_ok(i_set_ss, c_MS_MAX_BCD);
    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_ss_wrap   = (r_ss == c_MS_MAX_BCD);
    assign w_mm_wrap   = (r_mm == c_MS_MAX_BCD);
    assign w_hh_wrap   = (r_hh == c_HOUR_MAX_BCD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_tick_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // A load in the same cycle as an edge swallows that tick.
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_advance = w_edge & ~w_accept;
                if (i_pause)
                    w_state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!i_pause)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hh         <= 8'h00;
            r_mm         <= 8'h00;
            r_ss         <= 8'h00;
            r_set_err    <= 1'b0;
            r_sec_pulse  <= 1'b0;
            r_min_pulse  <= 1'b0;
            r_hour_pulse <= 1'b0;
            r_day_pulse  <= 1'b0;
        end else begin
            r_set_err    <= w_accept & ~w_legal;
            r_sec_pulse  <= w_advance;
            r_min_pulse  <= w_advance & w_ss_wrap;
            r_hour_pulse <= w_advance & w_ss_wrap & w_mm_wrap;
            r_day_pulse  <= w_advance & w_ss_wrap & w_mm_wrap & w_hh_wrap;
            if (w_accept) begin
                if (w_legal) begin
                    r_hh <= i_set_hh;
                    r_mm <= i_set_mm;
                    r_ss <= i_set_ss;
                end
            end else if (w_advance) begin
                r_ss <= f_bcd_inc(r_ss, c_MS_MAX_BCD);
                if (w_ss_wrap)
                    r_mm <= f_bcd_inc(r_mm, c_MS_MAX_BCD);
                if (w_ss_wrap && w_mm_wrap)
                    r_hh <= f_bcd_inc(r_hh, c_HOUR_MAX_BCD);
            end
        end
    end

    assign o_hh         = r_hh;
    assign o_mm         = r_mm;
    assign o_ss         = r_ss;
    assign o_set_err    = r_set_err;
    assign o_sec_pulse  = r_sec_pulse;
    assign o_min_pulse  = r_min_pulse;
    assign o_hour_pulse = r_hour_pulse;
    assign o_day_pulse  = r_day_pulse;

endmodule

`default_nettype wire
